// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg: shared types and defaults for the multiply/add arbiter
package mul_arb_pkg;
  typedef enum logic {OP_MUL = 1'b0, OP_ADD = 1'b1} op_t;
  localparam int MUL_ARB_W_DEF = 8;
  localparam int MUL_ARB_NREQ_DEF = 4;
  localparam int MUL_ARB_LAT_MAX = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0] N = (IW+1)'(NREQ);
  logic [IW:0] s;
  logic [IW-1:0] j;
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    s = '0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      j = IW'(s >= N ? s - N : s);
      if (en && !found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin shared signed multiply/add datapath with a tagged result pipeline
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int W = MUL_ARB_W_DEF,
  parameter int NREQ = MUL_ARB_NREQ_DEF,
  parameter int LAT = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_op,
  input  logic [NREQ*W-1:0]       req_a,
  input  logic [NREQ*W-1:0]       req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [W-1:0]            res_data,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] ptr, gidx;
  logic [W-1:0] av [NREQ];
  logic [W-1:0] bv [NREQ];
  logic [W-1:0] a, b, y;
  logic stall, accept;
  logic vld [LAT];
  logic [IW-1:0] id [LAT];
  logic [W-1:0] dat [LAT];
  genvar s, p;
  for (s = 0; s < NREQ; s++) begin : g_unpack
    assign av[s] = req_a[s*W +: W];
    assign bv[s] = req_b[s*W +: W];
  end
  assign stall = res_valid & ~res_ready;
  assign accept = |req_ready;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req(req_valid),
    .ptr(ptr),
    .en(~stall & ~Reset),
    .grant(req_ready),
    .idx(gidx)
  );
  assign a = av[gidx];
  assign b = bv[gidx];
  assign y = op_t'(req_op[gidx]) == OP_ADD ? a + b : W'($signed(a) * $signed(b));
  always_ff @(posedge Clock)
    if (Reset) ptr <= '0;
    else if (accept) ptr <= gidx == IW'(NREQ-1) ? '0 : gidx + 1'b1;
  always_ff @(posedge Clock)
    if (Reset) begin
      vld[0] <= 1'b0;
      id[0] <= '0;
      dat[0] <= '0;
    end else if (!stall) begin
      vld[0] <= accept;
      id[0] <= gidx;
      dat[0] <= y;
    end
  // all stages move together; a stall freezes the whole pipe
  for (p = 1; p < LAT; p++) begin : g_pipe
    always_ff @(posedge Clock)
      if (Reset) begin
        vld[p] <= 1'b0;
        id[p] <= '0;
        dat[p] <= '0;
      end else if (!stall) begin
        vld[p] <= vld[p-1];
        id[p] <= id[p-1];
        dat[p] <= dat[p-1];
      end
  end
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT; i++) busy = busy | vld[i];
  end
  assign res_valid = vld[LAT-1];
  assign res_id = id[LAT-1];
  assign res_data = dat[LAT-1];
endmodule
